// File: rtl/in_debounce_pkg.sv
// Shared types and constants for the simple_fpga_cvs input conditioning path.
package simple_fpga_cvs_pkg;

  localparam int NUM_INPUTS              = 5;
  localparam int DEBOUNCE_10MS_AT_300MHZ = 3_000_000;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } debounce_state_t;

endpackage

// File: rtl/in_debounce_if.sv
// Raw switch inputs in, debounced level and edge pulses out.
interface in_debounce_if
  import simple_fpga_cvs_pkg::*;
#(
  parameter int N = NUM_INPUTS
);
  logic [N-1:0] in;
  logic [N-1:0] db_out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  modport master (output in, input db_out, rise, fall);
  modport slave  (input in, output db_out, rise, fall);
endinterface

// File: rtl/in_debounce_channel.sv
// One input channel: synchroniser, stability counter and STABLE/PENDING FSM.
module debounce_channel
  import simple_fpga_cvs_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_300MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic db_out,
  output logic rise,
  output logic fall
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  debounce_state_t        state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_out_q, db_out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], in};
  assign sync   = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    db_out_d = db_out_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (sync != db_out_q) begin
          state_d = PENDING;
          cnt_d   = CW'(1);
        end
      end
      PENDING: begin
        if (sync == db_out_q) begin
          // glitch shorter than the window: drop it without touching outputs
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE;
          cnt_d    = '0;
          db_out_d = sync;
          rise_d   = sync;
          fall_d   = ~sync;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= STABLE;
      cnt_q    <= '0;
      db_out_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      db_out_q <= db_out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign db_out = db_out_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/in_debounce.sv
// Debounces NUM_INPUTS raw switch inputs with one independent channel each.
module in_debounce #(
  parameter int NUM_INPUTS      = simple_fpga_cvs_pkg::NUM_INPUTS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = simple_fpga_cvs_pkg::DEBOUNCE_10MS_AT_300MHZ
) (
  input logic           clk,
  input logic           rst,
  in_debounce_if.slave  bus
);

  logic [NUM_INPUTS-1:0] db_out_w;
  logic [NUM_INPUTS-1:0] rise_w;
  logic [NUM_INPUTS-1:0] fall_w;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .in     (bus.in[i]),
      .db_out (db_out_w[i]),
      .rise   (rise_w[i]),
      .fall   (fall_w[i])
    );
  end

  assign bus.db_out = db_out_w;
  assign bus.rise   = rise_w;
  assign bus.fall   = fall_w;

endmodule

// File: tb/tb_in_debounce.sv
// Directed bench for in_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_in_debounce;

  localparam int NI = 5;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  in_debounce_if #(.N(NI)) bus ();

  in_debounce #(
    .NUM_INPUTS      (NI),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NI-1:0] got, input logic [NI-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges; on edge 'at' (0 = never) db_out moves db0->db1 and mask pulses on rise or fall
  task automatic watch(input string tag, input int n, input int at, input logic [NI-1:0] mask,
                       input bit is_rise, input logic [NI-1:0] db0, input logic [NI-1:0] db1);
    for (int e = 1; e <= n; e++) begin
      tick();
      chk($sformatf("%s_db@%0d", tag, e), bus.db_out, (at != 0 && e >= at) ? db1 : db0);
      chk($sformatf("%s_rise@%0d", tag, e), bus.rise, (e == at && is_rise) ? mask : '0);
      chk($sformatf("%s_fall@%0d", tag, e), bus.fall, (e == at && !is_rise) ? mask : '0);
    end
  endtask

  initial begin
    logic [NI-1:0] v;
    rst    = 1'b1;
    bus.in = '0;
    repeat (3) tick();
    chk("rst_db", bus.db_out, '0);
    chk("rst_rise", bus.rise, '0);
    chk("rst_fall", bus.fall, '0);
    rst = 1'b0;

    // clean edge on channel 0
    bus.in = 5'b00001;
    watch("clean_r", 8, 6, 5'b00001, 1'b1, 5'b00000, 5'b00001);
    bus.in = 5'b00000;
    watch("clean_f", 8, 6, 5'b00001, 1'b0, 5'b00001, 5'b00000);

    // 3-cycle glitch rejected
    bus.in = 5'b00010;
    watch("g3_hi", 3, 0, '0, 1'b1, '0, '0);
    bus.in = 5'b00000;
    watch("g3_lo", 10, 0, '0, 1'b1, '0, '0);

    // 4-cycle pulse accepted, then fall 4 cycles after sync goes low
    bus.in = 5'b00010;
    watch("g4_hi", 4, 0, '0, 1'b1, '0, '0);
    bus.in = 5'b00000;
    watch("g4_acc", 3, 2, 5'b00010, 1'b1, 5'b00000, 5'b00010);
    watch("g4_fall", 8, 3, 5'b00010, 1'b0, 5'b00010, 5'b00000);

    // bounce on channel 2, final change to 1
    for (int k = 0; k < 20; k++) begin
      v      = '0;
      v[2]   = (k % 2 == 0);
      bus.in = v;
      watch($sformatf("bounce%0d", k), 1, 0, '0, 1'b1, '0, '0);
    end
    bus.in = 5'b00100;
    watch("bounce_r", 10, 6, 5'b00100, 1'b1, 5'b00000, 5'b00100);
    bus.in = 5'b00000;
    watch("bounce_f", 10, 6, 5'b00100, 1'b0, 5'b00100, 5'b00000);

    // simultaneous channels; async reset asserted while rise is high
    bus.in = 5'b10101;
    watch("simul", 6, 6, 5'b10101, 1'b1, 5'b00000, 5'b10101);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_db", bus.db_out, '0);
    chk("arst_rise", bus.rise, '0);
    chk("arst_fall", bus.fall, '0);
    watch("arst_hold", 2, 0, '0, 1'b1, '0, '0);
    rst = 1'b0;
    watch("post_rst", 8, 6, 5'b10101, 1'b1, 5'b00000, 5'b10101);
    bus.in = 5'b00000;
    watch("simul_f", 8, 6, 5'b10101, 1'b0, 5'b10101, 5'b00000);

    // reset while channel 3 is pending, input held high through it
    bus.in = 5'b01000;
    watch("pend", 2, 0, '0, 1'b1, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("pend_rst_db", bus.db_out, '0);
    watch("pend_hold", 3, 0, '0, 1'b1, '0, '0);
    rst = 1'b0;
    watch("pend_rel", 8, 6, 5'b01000, 1'b1, 5'b00000, 5'b01000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
